// File: rtl/dma_irq_ctrl.sv
// DMA interrupt aggregator: sticky done/error status, per-source and global enables,
// registered CPU interrupt, AXI4-Lite register window. Optional coalescing via DMA_IRQ_COALESCE_EN.
module dma_irq_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    input  logic [NUM_CHANNELS-1:0] irq_done,
    input  logic [NUM_CHANNELS-1:0] irq_error,
    output logic                    irq_out
);

    localparam int NC = NUM_CHANNELS;

    logic [NC-1:0] raw_done, raw_err, en_done, en_err;
    logic [NC-1:0] prev_done, prev_err;
    logic [NC-1:0] set_done, set_err, w1c_done, w1c_err;
    logic [NC-1:0] pend_done, pend_err;
    logic [NC-1:0] wr_lo, wr_hi, msk_lo, msk_hi;
    logic          gie;
    logic          aw_ready, b_valid, ar_ready, r_valid;
    logic [31:0]   r_data, rd_word;
    logic          irq_q, irq_next;
    logic          wr_fire, rd_fire;
    logic [2:0]    wr_sel, rd_sel;
    logic          unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                             S_AXI_WDATA, S_AXI_WSTRB};

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = 2'b00;
    assign irq_out       = irq_q;

    assign wr_fire = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = ar_ready & S_AXI_ARVALID;
    assign wr_sel  = S_AXI_AWADDR[4:2];
    assign rd_sel  = S_AXI_ARADDR[4:2];

    // Done bits live in byte 0 and error bits in byte 1, so each field obeys one strobe
    assign msk_lo = {NC{S_AXI_WSTRB[0]}};
    assign msk_hi = {NC{S_AXI_WSTRB[1]}};
    assign wr_lo  = S_AXI_WDATA[NC-1:0] & msk_lo;
    assign wr_hi  = S_AXI_WDATA[8 +: NC] & msk_hi;

    assign set_done  = irq_done & ~prev_done;
    assign set_err   = irq_error & ~prev_err;
    assign w1c_done  = (wr_fire && wr_sel == 3'd0) ? wr_lo : '0;
    assign w1c_err   = (wr_fire && wr_sel == 3'd0) ? wr_hi : '0;
    assign pend_done = raw_done & en_done;
    assign pend_err  = raw_err & en_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            aw_ready <= ~aw_ready & ~b_valid & S_AXI_AWVALID & S_AXI_WVALID;
            if (wr_fire)
                b_valid <= 1'b1;
            else if (S_AXI_BREADY)
                b_valid <= 1'b0;
            ar_ready <= ~ar_ready & ~r_valid & S_AXI_ARVALID;
            if (rd_fire) begin
                r_valid <= 1'b1;
                r_data  <= rd_word;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    // A new event in the same cycle as a W1C of that bit must survive, so set is OR-ed last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_done  <= '0;
            raw_err   <= '0;
            prev_done <= '0;
            prev_err  <= '0;
            en_done   <= '0;
            en_err    <= '0;
            gie       <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            prev_done <= irq_done;
            prev_err  <= irq_error;
            raw_done  <= (raw_done & ~w1c_done) | set_done;
            raw_err   <= (raw_err & ~w1c_err) | set_err;
            if (wr_fire && wr_sel == 3'd1) begin
                en_done <= (en_done & ~msk_lo) | wr_lo;
                en_err  <= (en_err & ~msk_hi) | wr_hi;
            end
            if (wr_fire && wr_sel == 3'd3 && S_AXI_WSTRB[0])
                gie <= S_AXI_WDATA[0];
            irq_q <= irq_next;
        end
    end

`ifdef DMA_IRQ_COALESCE_EN
    logic [7:0]    thresh;
    logic [15:0]   timeout;
    logic [NC-1:0] prev_pend;
    logic [NC-1:0] new_pend;
    logic [3:0]    coal_cnt, cnt_next;
    logic [4:0]    cnt_sum;
    logic [15:0]   coal_timer, timer_next;

    assign new_pend = pend_done & ~prev_pend;

    // Count fresh pending done bits and age the batch; both restart once nothing is pending
    always_comb begin
        cnt_sum    = {1'b0, coal_cnt};
        cnt_next   = '0;
        timer_next = '0;
        for (int i = 0; i < NC; i++)
            cnt_sum = cnt_sum + {4'b0, new_pend[i]};
        if (|pend_done) begin
            cnt_next   = (cnt_sum > 5'd15) ? 4'hF : cnt_sum[3:0];
            timer_next = (coal_timer == 16'hFFFF) ? coal_timer : coal_timer + 16'd1;
        end
        irq_next = gie & ((|pend_err) |
                   ((|pend_done) & (({4'b0, cnt_next} >= thresh) |
                                    ((timeout != 16'd0) && (timer_next >= timeout)))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh     <= '0;
            timeout    <= '0;
            prev_pend  <= '0;
            coal_cnt   <= '0;
            coal_timer <= '0;
        end else begin
            prev_pend  <= pend_done;
            coal_cnt   <= cnt_next;
            coal_timer <= timer_next;
            if (wr_fire && wr_sel == 3'd4) begin
                if (S_AXI_WSTRB[0]) thresh        <= S_AXI_WDATA[7:0];
                if (S_AXI_WSTRB[1]) timeout[7:0]  <= S_AXI_WDATA[15:8];
                if (S_AXI_WSTRB[2]) timeout[15:8] <= S_AXI_WDATA[23:16];
            end
        end
    end
`else
    assign irq_next = gie & (|{pend_done, pend_err});
`endif

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            3'd0: begin
                rd_word[NC-1:0] = raw_done;
                rd_word[8 +: NC] = raw_err;
            end
            3'd1: begin
                rd_word[NC-1:0] = en_done;
                rd_word[8 +: NC] = en_err;
            end
            3'd2: begin
                rd_word[NC-1:0] = pend_done;
                rd_word[8 +: NC] = pend_err;
            end
            3'd3: rd_word[0] = gie;
`ifdef DMA_IRQ_COALESCE_EN
            3'd4: rd_word[23:0] = {timeout, thresh};
`endif
            default: rd_word = '0;
        endcase
    end

endmodule
